// File: rtl/adc_if_pkg.sv
// Shared constants and state encoding for the three-wire ADC link.
// Used by both the controller and the responder.
package adc_if_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int LEAD_ZEROS      = 4;
  localparam int ADDR_FIRST_RISE = 2;
  localparam int ADDR_BITS       = 3;
  localparam int NUM_CH          = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    TAIL  = 2'd2
  } adc_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer plus history flop.
// Ports: clk_i, reset_i, d_i in; level_o, rise_o, fall_o single-cycle strobes.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/adc_responder.sv
// Device-side responder for the three-wire ADC link: decodes the address
// and shifts back {4'b0, ch_data[ch]}; ports: clk_50M, reset, adc_sclk,
// adc_cs_n, din, ch_data in; dout, frame_done, cur_addr, next_addr out.
module adc_responder
  import adc_if_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12
) (
  input  logic                        clk_50M,
  input  logic                        reset,
  input  logic                        adc_sclk,
  input  logic                        adc_cs_n,
  input  logic                        din,
  input  logic [NUM_CH*DATA_W-1:0]    ch_data,
  output logic                        dout,
  output logic                        frame_done,
  output logic [ADDR_BITS-1:0]        cur_addr,
  output logic [ADDR_BITS-1:0]        next_addr
);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl_unused;
  logic din_s, din_unused_rise, din_unused_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk_i   (clk_50M),
    .reset_i (reset),
    .d_i     (adc_sclk),
    .level_o (sclk_lvl_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk_i   (clk_50M),
    .reset_i (reset),
    .d_i     (adc_cs_n),
    .level_o (cs_lvl_unused),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .clk_i   (clk_50M),
    .reset_i (reset),
    .d_i     (din),
    .level_o (din_s),
    .rise_o  (din_unused_rise),
    .fall_o  (din_unused_fall)
  );

  adc_state_e              state_q, state_d;
  logic [4:0]              rcnt_q, rcnt_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [ADDR_BITS-1:0]    ash_q, ash_d;
  logic [ADDR_BITS-1:0]    cur_q, cur_d;
  logic [ADDR_BITS-1:0]    nxt_q, nxt_d;
  logic                    dout_q, dout_d;
  logic                    done_q, done_d;

  logic [DATA_W-1:0]       ch_val;
  logic [FRAME_BITS-1:0]   load_word;
  logic                    in_addr;

  always_comb begin
    ch_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (nxt_q == ADDR_BITS'(k)) ch_val = ch_data[k*DATA_W +: DATA_W];
    end
  end

  assign load_word = {{LEAD_ZEROS{1'b0}}, ch_val};

  assign in_addr = (rcnt_q >= 5'(ADDR_FIRST_RISE)) &&
                   (rcnt_q <  5'(ADDR_FIRST_RISE + ADDR_BITS));

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    shreg_d = shreg_q;
    ash_d   = ash_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    if (cs_rise) begin
      // Deselect wins over everything; a partial address is dropped.
      state_d = IDLE;
      dout_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = FRAME;
            shreg_d = load_word;
            cur_d   = nxt_q;
            rcnt_d  = '0;
            dout_d  = 1'b0;
          end
        end
        FRAME: begin
          if (sclk_rise) begin
            rcnt_d = rcnt_q + 5'd1;
            if (in_addr) ash_d = {ash_q[ADDR_BITS-2:0], din_s};
            if (rcnt_q == 5'(FRAME_BITS - 1)) begin
              nxt_d   = ash_q;
              done_d  = 1'b1;
              state_d = TAIL;
            end
          end else if (sclk_fall && rcnt_q != '0) begin
            // Falls before the first rise are idle-high SCLK, not data.
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
            dout_d  = shreg_q[FRAME_BITS-2];
          end
        end
        TAIL: begin
          if (sclk_fall) begin
            // Continuous mode: this fall starts the next frame.
            state_d = FRAME;
            shreg_d = load_word;
            cur_d   = nxt_q;
            rcnt_d  = '0;
            dout_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      shreg_q <= '0;
      ash_q   <= '0;
      cur_q   <= '0;
      nxt_q   <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      shreg_q <= shreg_d;
      ash_q   <= ash_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign dout       = dout_q;
  assign frame_done = done_q;
  assign cur_addr   = cur_q;
  assign next_addr  = nxt_q;

endmodule

// File: tb/tb_adc_responder.sv
// Directed self-checking bench for adc_responder.
// Table of framed transfers plus hand sequences for corner cases.
module tb_adc_responder;

  localparam int PH = 6;

  logic        clk_50M = 1'b0;
  logic        reset;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic        din;
  logic [95:0] ch_data;
  logic        dout;
  logic        frame_done;
  logic [2:0]  cur_addr;
  logic [2:0]  next_addr;

  adc_responder dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .adc_sclk   (adc_sclk),
    .adc_cs_n   (adc_cs_n),
    .din        (din),
    .ch_data    (ch_data),
    .dout       (dout),
    .frame_done (frame_done),
    .cur_addr   (cur_addr),
    .next_addr  (next_addr)
  );

  always #10 clk_50M = ~clk_50M;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic fd_prev = 1'b0;
  logic [95:0] ch_base;
  logic [95:0] ch_mod;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_50M) begin
    if (fd_prev) chk("frame_done_width", {31'd0, frame_done}, 32'd0);
    if (frame_done) done_cnt++;
    fd_prev = frame_done;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic run_frame(input logic [2:0] a, input bit lower_cs,
                           input bit raise_cs, input int mod_rise,
                           output logic [15:0] rx,
                           output logic [2:0] cur_mid);
    rx = '0;
    cur_mid = '0;
    if (lower_cs) begin
      adc_cs_n = 1'b0;
      wclk(PH);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == mod_rise) ch_data = ch_mod;
      rx[15-i] = dout;
      if (i == 8) cur_mid = cur_addr;
      din = (i == 2) ? a[2] : (i == 3) ? a[1] : (i == 4) ? a[0] : 1'b1;
      adc_sclk = 1'b1;
      wclk(PH);
      adc_sclk = 1'b0;
      wclk(PH);
    end
    if (raise_cs) begin
      adc_cs_n = 1'b1;
      wclk(PH);
    end
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] exp_rx;
    logic [2:0]  exp_cur;
    logic [2:0]  exp_next;
  } vec_t;

  vec_t vecs[7];
  logic [15:0] rx;
  logic [2:0]  cm;
  int d0;

  initial begin
    ch_base = {12'h001, 12'h789, 12'h7FF, 12'h456,
               12'hF0F, 12'h123, 12'h3C1, 12'hA5C};
    vecs[0] = '{3'd0, 16'h0A5C, 3'd0, 3'd0};
    vecs[1] = '{3'd5, 16'h0A5C, 3'd0, 3'd5};
    vecs[2] = '{3'd3, 16'h07FF, 3'd5, 3'd3};
    vecs[3] = '{3'd7, 16'h0F0F, 3'd3, 3'd7};
    vecs[4] = '{3'd1, 16'h0001, 3'd7, 3'd1};
    vecs[5] = '{3'd6, 16'h03C1, 3'd1, 3'd6};
    vecs[6] = '{3'd0, 16'h0789, 3'd6, 3'd0};

    ch_data  = ch_base;
    ch_mod   = ch_base;
    reset    = 1'b1;
    adc_sclk = 1'b0;
    adc_cs_n = 1'b1;
    din      = 1'b0;
    wclk(5);
    reset = 1'b0;
    wclk(PH);
    chk("rst_dout", {31'd0, dout}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_cur", {29'd0, cur_addr}, 32'd0);
    chk("rst_next", {29'd0, next_addr}, 32'd0);

    for (int j = 0; j < 7; j++) begin
      d0 = done_cnt;
      run_frame(vecs[j].addr, 1'b1, 1'b1, -1, rx, cm);
      chk($sformatf("v%0d_rx", j), {16'd0, rx}, {16'd0, vecs[j].exp_rx});
      chk($sformatf("v%0d_cur", j), {29'd0, cm}, {29'd0, vecs[j].exp_cur});
      chk($sformatf("v%0d_next", j), {29'd0, next_addr},
          {29'd0, vecs[j].exp_next});
      chk($sformatf("v%0d_done", j), done_cnt - d0, 32'd1);
    end

    d0 = done_cnt;
    run_frame(3'd2, 1'b1, 1'b0, -1, rx, cm);
    chk("cont0_rx", {16'd0, rx}, 32'h0A5C);
    run_frame(3'd4, 1'b0, 1'b0, -1, rx, cm);
    chk("cont1_rx", {16'd0, rx}, 32'h0123);
    chk("cont1_cur", {29'd0, cm}, 32'd2);
    run_frame(3'd6, 1'b0, 1'b1, -1, rx, cm);
    chk("cont2_rx", {16'd0, rx}, 32'h0456);
    chk("cont_done", done_cnt - d0, 32'd3);
    chk("cont_next", {29'd0, next_addr}, 32'd6);

    d0 = done_cnt;
    adc_cs_n = 1'b0;
    wclk(PH);
    for (int i = 0; i < 9; i++) begin
      din = 1'b1;
      adc_sclk = 1'b1;
      wclk(PH);
      if (i < 8) begin
        adc_sclk = 1'b0;
        wclk(PH);
      end
    end
    chk("part_dout_pre", {31'd0, dout}, 32'd1);
    adc_cs_n = 1'b1;
    wclk(3);
    chk("part_dout_0", {31'd0, dout}, 32'd0);
    adc_sclk = 1'b0;
    wclk(PH);
    chk("part_done", done_cnt - d0, 32'd0);
    chk("part_next", {29'd0, next_addr}, 32'd6);
    run_frame(3'd0, 1'b1, 1'b1, -1, rx, cm);
    chk("after_part_rx", {16'd0, rx}, 32'h0789);

    ch_data = ch_base;
    ch_data[11:0] = 12'hFFF;
    ch_mod = ch_data;
    ch_mod[11:0] = 12'h000;
    run_frame(3'd0, 1'b1, 1'b1, 8, rx, cm);
    chk("chg_rx_old", {16'd0, rx}, 32'h0FFF);
    run_frame(3'd5, 1'b1, 1'b1, -1, rx, cm);
    chk("chg_rx_new", {16'd0, rx}, 32'h0000);
    chk("chg_next", {29'd0, next_addr}, 32'd5);

    ch_data = ch_base;
    adc_cs_n = 1'b0;
    wclk(PH);
    for (int i = 0; i < 10; i++) begin
      din = 1'b1;
      adc_sclk = 1'b1;
      wclk(PH);
      adc_sclk = 1'b0;
      wclk(PH);
    end
    adc_sclk = 1'b1;
    wclk(2);
    chk("pre_rst_cur", {29'd0, cur_addr}, 32'd5);
    reset = 1'b1;
    wclk(1);
    chk("mrst_dout", {31'd0, dout}, 32'd0);
    chk("mrst_done", {31'd0, frame_done}, 32'd0);
    chk("mrst_cur", {29'd0, cur_addr}, 32'd0);
    chk("mrst_next", {29'd0, next_addr}, 32'd0);
    reset = 1'b0;
    adc_cs_n = 1'b1;
    adc_sclk = 1'b0;
    wclk(PH);
    d0 = done_cnt;
    run_frame(3'd0, 1'b1, 1'b1, -1, rx, cm);
    chk("post_rst_rx", {16'd0, rx}, 32'h0A5C);
    chk("post_rst_cur", {29'd0, cm}, 32'd0);
    chk("post_rst_done", done_cnt - d0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_responder.md
# adc_responder

Behavioural responder for the three-wire ADC serial interface: the device end of the link driven by our ADC controller. It oversamples `adc_sclk`, `adc_cs_n` and `din` on `clk_50M`, decodes the 3-bit channel address shifted in each frame, and returns a 16-bit frame on `dout`: four leading zeros, then a 12-bit channel value. It sits in place of the physical ADC for hardware-in-the-loop line-follower tests, with eight channel values fed in from test logic.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `adc_sclk`, `adc_cs_n` and `din`; legal range is 2–3.
- `DATA_W`, 12: conversion width; fixed at 12 by the frame format.
- `clk_50M`  in  1  system clock, 50 MHz; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `adc_sclk`  in  1  serial clock from the controller; asynchronous to `clk_50M` in principle.
- `adc_cs_n`  in  1  active-low chip select.
- `din`  in  1  serial address/control from the controller.
- `ch_data`  in  96  channel values; `ch_data[12*k +: 12]` is channel k, k = 0..7.
- `dout`  out  1  serial conversion data, MSB first.
- `frame_done`  out  1  one-cycle pulse on each completed 16-bit frame.
- `cur_addr`  out  3  channel being returned in the current frame.
- `next_addr`  out  3  channel address latched from the last completed frame.

## Operation
- **Input conditioning.** `adc_sclk` and `adc_cs_n` each pass through `SYNC_STAGES` flops, followed by one history flop, to produce single-cycle rise and fall strobes. `din` passes through the same depth so it stays aligned with the `adc_sclk` rise strobe.
- **Register widths.** Shift register 16 b; rise counter `rcnt` 5 b (0–16); address shifter 3 b.
- **States.**
  - IDLE: `adc_cs_n` high.
  - FRAME: counting edges.
  - TAIL: 16 rises seen, waiting for the next fall.
- **IDLE → FRAME** on a `adc_cs_n` fall strobe:
  - load shift register = {4'b0, `ch_data[12*next_addr +: 12]`};
  - `cur_addr` ← `next_addr`; `rcnt` ← 0;
  - `dout` ← 0 (bit 15).
- **FRAME, `adc_sclk` rise:**
  - `rcnt` ← `rcnt`+1;
  - on rises 2, 3 and 4 (0-based), shift `din` into the address shifter: ADD2, then ADD1, then ADD0.
- **FRAME, `adc_sclk` fall:**
  - only acted on when `rcnt` ≥ 1; a fall with `rcnt` = 0 is ignored, so either SCLK idle level is accepted;
  - shift the register left and drive the new MSB onto `dout`.
- **16th rise:**
  - `next_addr` ← address shifter;
  - `frame_done` pulses;
  - go to TAIL.
- **TAIL, `adc_sclk` fall with `adc_cs_n` still low (continuous mode):**
  - reload the shift register with {4'b0, `ch_data[12*next_addr +: 12]`};
  - `cur_addr` ← `next_addr`; `rcnt` ← 0;
  - `dout` ← 0;
  - go to FRAME with the fall already consumed, so the next fall shifts normally.
- **`adc_cs_n` rise strobe in any state:**
  - go to IDLE; `dout` ← 0.
  - If the frame was incomplete (fewer than 16 rises), `next_addr` and `frame_done` are untouched and the partial address is discarded.
- **Simultaneous strobes in one cycle.** The `adc_cs_n` rise takes priority over any `adc_sclk` strobe. An `adc_sclk` strobe in the same cycle as a `adc_cs_n` fall is ignored.
- **Value sampling.** `ch_data` is sampled only at a load (the `adc_cs_n` fall or a continuous-mode reload). Changes mid-frame do not affect the frame in flight.
- **First frame after reset** returns channel 0.

## Timing
- Reset values:
  - `dout` = 0, `frame_done` = 0, `cur_addr` = 0, `next_addr` = 0;
  - state IDLE, `rcnt` = 0, shift register = 0;
  - synchronizer flops = 1 for `adc_cs_n`, 0 for the others.
- Reset asserted mid-frame: every output is at its reset value on the next `clk_50M` edge. A frame resumes only after a fresh `adc_cs_n` fall.
- Latency from a pin edge to its effect is `SYNC_STAGES`+1 `clk_50M` cycles: 3 at the default.
  - `dout` changes 3 cycles after an `adc_sclk` fall.
  - `frame_done` asserts 3 cycles after the 16th `adc_sclk` rise.
- Input constraints:
  - `adc_sclk` high and low phases each ≥ `SYNC_STAGES`+2 `clk_50M` cycles;
  - `adc_cs_n` fall to first `adc_sclk` fall ≥ same;
  - with these met, `dout` is stable at the controller's next rising SCLK edge.
- `frame_done` is exactly one `clk_50M` cycle wide.

## Structure
- Shared package `adc_if_pkg` holds:
  - `FRAME_BITS` = 16, `LEAD_ZEROS` = 4, `ADDR_FIRST_RISE` = 2, `ADDR_BITS` = 3, `NUM_CH` = 8;
  - the state encoding IDLE/FRAME/TAIL.
- The controller side uses the same package.
- One sub-module, `sync_edge`: a `SYNC_STAGES` synchronizer plus history flop, giving `level`, `rise` and `fall` outputs.
  - Instantiated for `adc_sclk` and `adc_cs_n`; `din` uses its `level` output only.

## Test plan
- Reset, then one frame with address 3'b000, `ch_data` ch0 = 12'hA5C: `dout` sequence is 0000_1010_0101_1100; `frame_done` pulses once; `next_addr` = 0.
- Frame 1 sends ADD = 3'b101, frame 2 sends any address, ch5 = 12'h7FF: frame 2 returns 0000_0111_1111_1111 and `cur_addr` = 5 during frame 2.
- Continuous mode, 48 SCLK cycles with `adc_cs_n` held low, addresses 2, 4, 6 and ch2/4/6 = 12'h123/12'h456/12'h789: three `frame_done` pulses, and frames return ch0, ch2, ch4.
- `adc_cs_n` rises after 9 rises while sending ADD = 3'b111: no `frame_done`, `next_addr` unchanged, `dout` = 0 within 3 cycles.
- `ch_data` for ch0 changes from 12'hFFF to 12'h000 at rise 8: frame still returns 12'hFFF; the following frame returns 12'h000.
- `reset` pulse at rise 10: all outputs at reset values next cycle; the next full frame returns ch0 with `next_addr` previously 0.
